// File: rtl/async_fifo_wr_port.sv
// Write-side front end of the dual-clock FIFO.
// A 2-entry skid buffer accepts words from the producer and drives the RAM write port.
// It mirrors the write controller's full test, so each word reaches RAM in the same
// cycle that the write pointer advances.
// Optional: define ASYNC_FIFO_WR_PORT_AFULL_EN to add the P_AFULL_THR parameter and
// the registered o_almost_full output.
module async_fifo_wr_port #(
    parameter int P_PTR_MSB   = 4,
    parameter int P_DATA_W    = 32
`ifdef ASYNC_FIFO_WR_PORT_AFULL_EN
    ,
    parameter int P_AFULL_THR = 28
`endif
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [P_DATA_W-1:0] i_data,
    input  logic [P_PTR_MSB:0]  i_wr_ptr,
    input  logic [P_PTR_MSB:0]  i_rd_ptr,
    output logic                o_inc,
    output logic                o_mem_we,
    output logic [P_PTR_MSB:0]  o_mem_addr,
    output logic [P_DATA_W-1:0] o_mem_data,
    output logic [P_PTR_MSB:0]  o_level
`ifdef ASYNC_FIFO_WR_PORT_AFULL_EN
    ,
    output logic                o_almost_full
`endif
);

    // Occupancy of the out register plus the skid register.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_t;

    localparam logic [P_PTR_MSB:0] LP_PTR_ONE = {{P_PTR_MSB{1'b0}}, 1'b1};

    buf_state_t            r_state;
    buf_state_t            w_state_nxt;
    logic                  r_ready;
    logic [P_DATA_W-1:0]   r_out_data;
    logic [P_DATA_W-1:0]   r_skid_data;

    logic [P_PTR_MSB:0]    w_wr_ptr_inc;
    logic                  w_space;
    logic                  w_out_valid;
    logic                  w_fire;
    logic                  w_accept;
    logic                  w_load_out_in;
    logic                  w_load_out_skid;
    logic                  w_load_skid;

    // This must match the controller's full test bit for bit. Otherwise a word could
    // be written without the pointer advancing, or the pointer could advance without
    // a word being written.
    assign w_wr_ptr_inc = i_wr_ptr + LP_PTR_ONE;
    assign w_space      = (w_wr_ptr_inc != i_rd_ptr);

    assign w_out_valid  = (r_state != ST_EMPTY);
    assign w_fire       = w_out_valid & w_space & ~i_rst;
    assign w_accept     = i_valid & r_ready;

    // The controller applies its own full test to o_inc. Masking o_inc during reset
    // means neither the RAM nor the pointer moves while buffered words are discarded.
    assign o_inc        = w_out_valid & ~i_rst;
    assign o_mem_we     = w_fire;
    assign o_mem_addr   = i_wr_ptr;
    assign o_mem_data   = r_out_data;
    assign o_ready      = r_ready;
    assign o_level      = i_wr_ptr - i_rd_ptr;

    // Next-state and register-load decode for the skid buffer.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        w_state_nxt     = r_state;
        w_load_out_in   = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        unique case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt   = ST_ONE;
                    w_load_out_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && w_fire) begin
                    w_load_out_in = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = ST_TWO;
                    w_load_skid = 1'b1;
                end else if (w_fire) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_fire) begin
                    w_state_nxt     = ST_ONE;
                    w_load_out_skid = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // State register. o_ready is computed from the next state so it never leaves a bubble.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (i_rst) begin
            r_state <= ST_EMPTY;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt != ST_TWO);
        end
    end

    // Data registers: the out register feeds RAM, and the skid register catches the
    // word that arrives while the out register is stalled.
    always_ff @(posedge i_clk) begin
        // NOTE: the data registers are reset as well, because o_mem_data must read 0 after reset.
        if (i_rst) begin
            r_out_data  <= '0;
            r_skid_data <= '0;
        end else begin
            if (w_load_out_in) begin
                r_out_data <= i_data;
            end else if (w_load_out_skid) begin
                r_out_data <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_data <= i_data;
            end
        end
    end

`ifdef ASYNC_FIFO_WR_PORT_AFULL_EN
    localparam logic [P_PTR_MSB:0] LP_AFULL_THR = P_AFULL_THR[P_PTR_MSB:0];

    logic r_almost_full;

    // Registered throttle hint for the producer. It does not gate o_ready.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_almost_full <= 1'b0;
        end else begin
            r_almost_full <= (o_level >= LP_AFULL_THR);
        end
    end

    assign o_almost_full = r_almost_full;
`endif

endmodule
